// File: rtl/line_address_composer_pkg.sv
// Shared cache address geometry and the line burst FSM state encoding.
package cache_pkg;
  localparam int unsigned TAG_W  = 28;
  localparam int unsigned SET_W  = 2;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned ADDR_W = TAG_W + SET_W + OFF_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/line_address_composer_if.sv
// Request channel from the cache controller, beat channel to memory, plus burst status.
interface line_address_composer_if;
  import cache_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [TAG_W-1:0]   req_tag;
  logic [SET_W-1:0]   req_set;
  logic [OFF_W-1:0]   req_offset;
  logic               req_write;
  logic               mem_valid;
  logic               mem_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_write;
  logic               mem_last;
  logic [OFF_W-1:0]   beat_offset;
  logic               done;
  logic               busy;

  modport slave (
    input  req_valid, req_tag, req_set, req_offset, req_write, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_write, mem_last, beat_offset, done, busy
  );

  modport master (
    output req_valid, req_tag, req_set, req_offset, req_write, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_write, mem_last, beat_offset, done, busy
  );
endinterface

// File: rtl/line_address_composer_beat_counter.sv
// Wrapping critical-word-first offset plus a separate beat count that flags the final beat.
module line_beat_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [OFF_W-1:0] i_load_offset,
  input  logic             i_advance,
  output logic [OFF_W-1:0] o_offset,
  output logic             o_last
);
  logic [OFF_W-1:0] r_offset;
  logic [OFF_W-1:0] r_count;

  // Offset wraps by plain truncation; the count alone decides the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_offset <= i_load_offset;
      r_count  <= '0;
    end else if (i_advance) begin
      r_offset <= r_offset + 1'b1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_offset = r_offset;
  assign o_last   = (r_count == '1);
endmodule

// File: rtl/line_address_composer.sv
// Rebuilds line addresses {tag, set, offset} and issues one cache line as a wrapping burst.
module line_address_composer
  import cache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  line_address_composer_if.slave bus
);
  state_t             r_state;
  logic [TAG_W-1:0]   r_tag;
  logic [SET_W-1:0]   r_set;
  logic               r_write;
  logic               r_mem_valid;
  logic               r_done;
  logic               r_busy;
  logic               w_accept;
  logic               w_beat;
  logic               w_last;
  logic [OFF_W-1:0]   w_offset;

  assign w_accept = bus.req_valid && bus.req_ready;
  assign w_beat   = r_mem_valid && bus.mem_ready;

  line_beat_counter u_beat_counter (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_accept),
    .i_load_offset (bus.req_offset),
    .i_advance     (w_beat),
    .o_offset      (w_offset),
    .o_last        (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tag       <= '0;
      r_set       <= '0;
      r_write     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state     <= BURST;
            r_tag       <= bus.req_tag;
            r_set       <= bus.req_set;
            r_write     <= bus.req_write;
            r_mem_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        BURST: begin
          if (w_beat && w_last) begin
            r_state     <= DONE;
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Only the request side looks at rst directly, so nothing is accepted during reset.
  assign bus.req_ready   = (r_state == IDLE) && !rst;
  assign bus.mem_valid   = r_mem_valid;
  assign bus.mem_addr    = {r_tag, r_set, w_offset};
  assign bus.mem_write   = r_write;
  assign bus.mem_last    = r_mem_valid && w_last;
  assign bus.beat_offset = w_offset;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_line_address_composer.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor checks every presented beat.
module tb_line_address_composer;
  import cache_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cycnt  = 0;
  beat_t sb[$];

  line_address_composer_if bus ();

  line_address_composer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycnt <= cycnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.mem_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got addr %h expected no beat", bus.mem_addr);
      end else begin
        beat_t e;
        e = sb[0];
        check("mem_addr", bus.mem_addr, e.addr);
        check("mem_last", {31'd0, bus.mem_last}, {31'd0, e.last});
        check("mem_write", {31'd0, bus.mem_write}, {31'd0, e.wr});
        check("beat_offset", {30'd0, bus.beat_offset}, {30'd0, e.addr[1:0]});
        if (bus.mem_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [TAG_W-1:0] tag, input logic [SET_W-1:0] set,
                       input logic [OFF_W-1:0] off, input logic wr, input logic keep,
                       output int acc);
    int    w;
    beat_t e;
    logic [OFF_W-1:0] o;
    bus.req_tag    = tag;
    bus.req_set    = set;
    bus.req_offset = off;
    bus.req_write  = wr;
    bus.req_valid  = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      tick();
      w++;
    end
    check("req_accept_wait", {31'd0, bus.req_ready}, 32'd1);
    acc = cycnt;
    for (int i = 0; i < 4; i++) begin
      o      = off + i[1:0];
      e.addr = {tag, set, o};
      e.wr   = wr;
      e.last = (i == 3);
      sb.push_back(e);
    end
    tick();
    if (!keep) bus.req_valid = 1'b0;
  endtask

  // Entered in the first beat cycle; drives mem_ready, stalling beat index stall_beat.
  task automatic run_burst(input int stall_beat, input int stall_len);
    int   cyc;
    int   beat;
    int   st;
    logic hs;
    cyc  = 0;
    beat = 0;
    st   = stall_len;
    while (!bus.done && cyc < 40) begin
      if (bus.mem_valid && beat == stall_beat && st > 0) begin
        bus.mem_ready = 1'b0;
        st--;
      end else begin
        bus.mem_ready = 1'b1;
      end
      check("req_ready_in_burst", {31'd0, bus.req_ready}, 32'd0);
      hs = bus.mem_valid && bus.mem_ready;
      tick();
      cyc++;
      if (hs) beat++;
    end
    check("done_latency", cyc, 4 + stall_len);
    check("req_ready_in_done", {31'd0, bus.req_ready}, 32'd0);
    check("busy_in_done", {31'd0, bus.busy}, 32'd1);
    check("mem_valid_in_done", {31'd0, bus.mem_valid}, 32'd0);
    tick();
    check("done_pulse_width", {31'd0, bus.done}, 32'd0);
    check("busy_after", {31'd0, bus.busy}, 32'd0);
    check("req_ready_after", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int acc1;
    int acc2;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_tag   = '0;
    bus.req_set   = '0;
    bus.req_offset= '0;
    bus.req_write = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (3) tick();
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_beat_offset", {30'd0, bus.beat_offset}, 32'd0);
    check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    check("rst_mem_last", {31'd0, bus.mem_last}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Refill, critical word 2: FFFFFFFA, FB, F8, F9
    issue(28'hFFFFFFF, 2'b10, 2'b10, 1'b0, 1'b0, acc1);
    run_burst(-1, 0);

    // Writeback from offset 0: 0, 1, 2, 3
    issue(28'h0000000, 2'b00, 2'b00, 1'b1, 1'b0, acc1);
    run_burst(-1, 0);

    // Three-cycle stall on the second beat: 12345677, 74, 75, 76
    issue(28'h1234567, 2'b01, 2'b11, 1'b0, 1'b0, acc1);
    run_burst(1, 3);

    // Back-to-back with fields changed mid-burst
    issue(28'hABCDEF0, 2'b11, 2'b01, 1'b1, 1'b1, acc1);
    bus.req_tag    = 28'h0F0F0F0;
    bus.req_set    = 2'b00;
    bus.req_offset = 2'b10;
    bus.req_write  = 1'b0;
    run_burst(-1, 0);
    issue(28'h0F0F0F0, 2'b00, 2'b10, 1'b0, 1'b0, acc2);
    check("b2b_spacing", acc2 - acc1, 6);
    run_burst(-1, 0);

    // Reset after the first beat
    issue(28'h5555555, 2'b01, 2'b00, 1'b0, 1'b0, acc1);
    bus.mem_ready = 1'b1;
    tick();
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("req_ready_in_rst", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check("midrst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_mem_addr", bus.mem_addr, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_done", {31'd0, bus.done}, 32'd0);
      check("midrst_no_valid", {31'd0, bus.mem_valid}, 32'd0);
    end
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/line_address_composer.md
# line_address_composer

Cache-side burst address generator that rebuilds full 32-bit memory addresses from the tag, set and offset fields kept by the cache, which is the inverse of the address split done on lookup. On a refill or writeback request it issues the four addresses of one cache line to the memory port with a valid/ready handshake. Addresses go out critical-word-first and wrap within the line. It sits between the cache controller and the memory interface.

## Interface
- TAG_W, 28, tag field width
- SET_W, 2, set index width
- OFF_W, 2, offset width; the line holds 2^OFF_W beats
- ADDR_W (localparam), TAG_W+SET_W+OFF_W = 32

Ports:
- clk  in  1  sole clock; all logic is posedge clk
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  controller has a line request
- req_ready  out  1  block can accept a request
- req_tag  in  TAG_W  tag of the line
- req_set  in  SET_W  set index of the line
- req_offset  in  OFF_W  critical (first) beat
- req_write  in  1  1 = writeback, 0 = refill
- mem_valid  out  1  mem_addr is valid
- mem_ready  in  1  memory accepts the current beat
- mem_addr  out  ADDR_W  address {tag, set, beat_offset}
- mem_write  out  1  latched req_write
- mem_last  out  1  current beat is the final beat of the line
- beat_offset  out  OFF_W  offset field of the current beat
- done  out  1  one-cycle pulse after the final beat is accepted
- busy  out  1  a burst is in progress (state != IDLE)

## Operation
- States:
  - IDLE: req_ready=1 (forced 0 while rst=1).
  - BURST: issuing beats.
  - DONE: one cycle with done=1.
- IDLE→BURST: on req_valid&&req_ready. Latch tag, set, req_write, and start offset = req_offset. Clear beat count.
- BURST: mem_valid=1.
  - On mem_valid&&mem_ready: beat_offset <= beat_offset+1, which wraps mod 2^OFF_W because it is plain OFF_W-bit truncation. Beat count increments.
  - mem_last=1 when beat count = 2^OFF_W−1.
  - A handshake with mem_last=1 moves to DONE.
- DONE→IDLE unconditionally. No request is accepted in DONE.
- mem_addr = {tag_q, set_q, beat_offset}. It is held stable while mem_valid=1 and mem_ready=0.
- Requests are ignored whenever req_ready=0. Field inputs are sampled only at acceptance.
- Reset mid-burst: the next edge returns to IDLE. No done pulse. The remaining beats are dropped.

## Timing
- Reset values: state IDLE, mem_valid 0, mem_addr 0, beat_offset 0, mem_write 0, mem_last 0, done 0, busy 0.
- Request accepted at edge N → mem_valid=1 with the first address from cycle N+1.
- With mem_ready held at 1, there is one beat per cycle:
  - Beats occupy cycles N+1..N+4.
  - done=1 in cycle N+5.
  - req_ready=1 again in cycle N+6.
- Minimum request-to-request spacing is 2^OFF_W+2 cycles.
- Stall: mem_ready=0 for k cycles extends the burst by k cycles. The address, mem_last and beat_offset do not change during the stall.
- All outputs are registered or decoded from registered state only. The exception is req_ready, which also gates on rst.

## Structure
- Shared package cache_pkg:
  - TAG_W, SET_W, OFF_W and derived ADDR_W, shared with the address splitter.
  - State enum (IDLE, BURST, DONE).
- One optional sub-module, line_beat_counter: a wrapping offset counter plus beat count, with inputs load/advance and outputs offset/last.
- The FSM and the address concatenation stay in the top module.

## Test plan
- Refill, mem_ready=1: tag 28'hFFFFFFF, set 2'b10, offset 2'b10 → mem_addr sequence 0xFFFFFFFA, 0xFFFFFFFB, 0xFFFFFFF8, 0xFFFFFFF9. mem_last only on 0xFFFFFFF9. mem_write=0. done exactly one cycle later.
- Offset 0 writeback: tag 0, set 0, offset 0, req_write=1 → addresses 0x0, 0x1, 0x2, 0x3. mem_write=1 throughout.
- Backpressure: mem_ready=0 for 3 cycles on beat 2 → mem_addr and mem_last frozen during the stall. Total burst is 7 cycles. Address order is unchanged.
- Back-to-back: second req_valid held high from the first acceptance → second request is accepted only in IDLE, 6 cycles after the first acceptance. req_ready=0 throughout BURST and DONE.
- Reset mid-burst: rst=1 after beat 1 → next cycle mem_valid=0, busy=0, done never pulses, mem_addr=0. req_ready=1 after rst drops.
- Field isolation: change req_tag/req_set during a burst → emitted addresses keep the latched fields.
